// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART command-frame receiver.
//   state_t       : framing FSM states
//   SYNC_DEFAULT  : default frame start byte
//   MAXLEN_DEFAULT: default maximum payload length in bytes
//   timer_width() : bit width of the inter-byte timeout counter
package uart_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_LEN  = 3'd2,
    S_PAY  = 3'd3,
    S_CHK  = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT   = 8'hAA;
  localparam int         MAXLEN_DEFAULT = 8;

  // The counter never needs to hold more than TIMEOUT-2, so $clog2(TIMEOUT)
  // bits always suffice; keep at least one bit for the degenerate TIMEOUT=2.
  function automatic int timer_width(input int timeout);
    int w;
    w = $clog2(timeout);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter.
//   clk, rstn : clock, synchronous active-low reset
//   clr       : restart the count (a byte arrived)
//   en        : count this cycle (a frame is in progress)
//   expire    : single-cycle pulse on the cycle the count reaches TIMEOUT-1
module uart_frame_timer
  import uart_frame_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int           W    = timer_width(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 2);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  // Cycles since the last byte equal count+1 during this cycle; flag the
  // cycle on which that reaches TIMEOUT-1. A byte on this cycle cancels it.
  assign expire = en && !clr && (count == LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// Command-frame sequencer behind the UART receiver.
// Frame format: SYNC, CMD, LEN, PAYLOAD[LEN], CKSUM (8-bit sum of CMD..PAYLOAD).
//   clk, rstn   : clock, synchronous active-low reset
//   rcv, data   : one-cycle byte strobe and byte from the UART receiver
//   frm_valid   : a good frame is held on frm_cmd/frm_len/frm_payload
//   frm_ready   : consumer accepts the held frame
//   frm_cmd     : command byte
//   frm_len     : payload length
//   frm_payload : payload, byte i at [8i+7:8i]
//   err_cksum   : pulse, checksum mismatch
//   err_len     : pulse, LEN above MAXLEN
//   err_timeout : pulse, inter-byte gap too long inside a frame
//   err_ovr     : pulse, byte dropped while a frame is held
//   busy        : FSM not idle
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int         MAXLEN  = MAXLEN_DEFAULT,
  parameter int         TIMEOUT = 50000,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rcv,
  input  logic [7:0]            data,
  output logic                  frm_valid,
  input  logic                  frm_ready,
  output logic [7:0]            frm_cmd,
  output logic [3:0]            frm_len,
  output logic [8*MAXLEN-1:0]   frm_payload,
  output logic                  err_cksum,
  output logic                  err_len,
  output logic                  err_timeout,
  output logic                  err_ovr,
  output logic                  busy
);

  state_t              state_q, state_n;
  logic [7:0]          cmd_q, cmd_n;
  logic [3:0]          len_q, len_n;
  logic [8*MAXLEN-1:0] pay_q, pay_n;
  logic [3:0]          idx_q, idx_n;
  logic [7:0]          sum_q, sum_n;
  logic                cksum_q, cksum_n;
  logic                lenerr_q, lenerr_n;
  logic                tout_q, tout_n;
  logic                ovr_q, ovr_n;
  logic                valid_q, busy_q;
  logic                timing;
  logic                expire;

  assign timing = (state_q == S_CMD) || (state_q == S_LEN) ||
                  (state_q == S_PAY) || (state_q == S_CHK);

  uart_frame_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (rcv),
    .en     (timing),
    .expire (expire)
  );

  always_comb begin
    state_n  = state_q;
    cmd_n    = cmd_q;
    len_n    = len_q;
    pay_n    = pay_q;
    idx_n    = idx_q;
    sum_n    = sum_q;
    cksum_n  = 1'b0;
    lenerr_n = 1'b0;
    tout_n   = 1'b0;
    ovr_n    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rcv && (data == SYNC)) begin
          state_n = S_CMD;
          pay_n   = '0;
          idx_n   = 4'd0;
          sum_n   = 8'd0;
        end
      end

      S_CMD: begin
        if (rcv) begin
          cmd_n   = data;
          sum_n   = sum_q + data;
          state_n = S_LEN;
        end else if (expire) begin
          tout_n  = 1'b1;
          state_n = S_IDLE;
        end
      end

      S_LEN: begin
        if (rcv) begin
          // Full 8-bit compare: a length byte like 8'h12 must not alias to 2.
          if (data > 8'(MAXLEN)) begin
            lenerr_n = 1'b1;
            state_n  = S_IDLE;
          end else begin
            len_n   = data[3:0];
            sum_n   = sum_q + data;
            state_n = (data == 8'd0) ? S_CHK : S_PAY;
          end
        end else if (expire) begin
          tout_n  = 1'b1;
          state_n = S_IDLE;
        end
      end

      S_PAY: begin
        if (rcv) begin
          for (int i = 0; i < MAXLEN; i++) begin
            if (idx_q == 4'(i)) pay_n[8*i +: 8] = data;
          end
          sum_n = sum_q + data;
          idx_n = idx_q + 4'd1;
          if ((idx_q + 4'd1) == len_q) state_n = S_CHK;
        end else if (expire) begin
          tout_n  = 1'b1;
          state_n = S_IDLE;
        end
      end

      S_CHK: begin
        if (rcv) begin
          if (data == sum_q) begin
            state_n = S_HOLD;
          end else begin
            cksum_n = 1'b1;
            state_n = S_IDLE;
          end
        end else if (expire) begin
          tout_n  = 1'b1;
          state_n = S_IDLE;
        end
      end

      S_HOLD: begin
        // Bytes cannot be buffered while the frame is held; report and drop.
        if (rcv) ovr_n = 1'b1;
        if (frm_ready) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      len_q    <= '0;
      pay_q    <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      cksum_q  <= 1'b0;
      lenerr_q <= 1'b0;
      tout_q   <= 1'b0;
      ovr_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      cmd_q    <= cmd_n;
      len_q    <= len_n;
      pay_q    <= pay_n;
      idx_q    <= idx_n;
      sum_q    <= sum_n;
      cksum_q  <= cksum_n;
      lenerr_q <= lenerr_n;
      tout_q   <= tout_n;
      ovr_q    <= ovr_n;
      valid_q  <= (state_n == S_HOLD);
      busy_q   <= (state_n != S_IDLE);
    end
  end

  assign frm_valid   = valid_q;
  assign frm_cmd     = cmd_q;
  assign frm_len     = len_q;
  assign frm_payload = pay_q;
  assign err_cksum   = cksum_q;
  assign err_len     = lenerr_q;
  assign err_timeout = tout_q;
  assign err_ovr     = ovr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: byte-level frame model compared every cycle,
// plus directed literal expectations for each scenario.
module tb_uart_frame_rx;

  localparam int         MAXLEN  = 8;
  localparam int         TIMEOUT = 16;
  localparam logic [7:0] SYNC    = 8'hAA;
  localparam int         PW      = 8 * MAXLEN;

  logic          clk = 1'b0;
  logic          rstn, rcv, frm_ready;
  logic [7:0]    data;
  logic          frm_valid, err_cksum, err_len, err_timeout, err_ovr, busy;
  logic [7:0]    frm_cmd;
  logic [3:0]    frm_len;
  logic [PW-1:0] frm_payload;

  int total = 0;
  int bad   = 0;

  uart_frame_rx #(
    .MAXLEN  (MAXLEN),
    .TIMEOUT (TIMEOUT),
    .SYNC    (SYNC)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rcv         (rcv),
    .data        (data),
    .frm_valid   (frm_valid),
    .frm_ready   (frm_ready),
    .frm_cmd     (frm_cmd),
    .frm_len     (frm_len),
    .frm_payload (frm_payload),
    .err_cksum   (err_cksum),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .err_ovr     (err_ovr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame model: bytes collected into a queue ----------------
  logic [7:0]    fb[$];
  bit            started = 0;
  bit            m_active = 0, m_hold = 0;
  int            m_gap = 0;
  logic          e_valid = 0, e_busy = 0;
  logic          e_cksum = 0, e_lenerr = 0, e_to = 0, e_ovr = 0;
  logic [7:0]    e_cmd = 0;
  logic [3:0]    e_len = 0;
  logic [PW-1:0] e_pay = '0;

  always @(posedge clk) begin
    int k;
    int s;
    started  = 1;
    e_cksum  = 0;
    e_lenerr = 0;
    e_to     = 0;
    e_ovr    = 0;
    if (!rstn) begin
      m_active = 0; m_hold = 0; m_gap = 0; fb.delete();
      e_valid = 0; e_cmd = 0; e_len = 0; e_pay = '0;
    end else if (m_hold) begin
      if (rcv) e_ovr = 1;
      if (frm_ready) begin m_hold = 0; e_valid = 0; end
    end else if (!m_active) begin
      if (rcv && data == SYNC) begin
        m_active = 1; fb.delete(); m_gap = 0; e_pay = '0;
      end
    end else if (rcv) begin
      m_gap = 0;
      if (fb.size() == 1 && int'(data) > MAXLEN) begin
        e_lenerr = 1; m_active = 0;
      end else begin
        fb.push_back(data);
        k = fb.size() - 1;
        if (k == 0) e_cmd = data;
        else if (k == 1) e_len = data[3:0];
        else if (k < int'(fb[1]) + 2) e_pay[8*(k-2) +: 8] = data;
        else begin
          s = 0;
          for (int i = 0; i < k; i++) s += int'(fb[i]);
          if (8'(s) == data) begin m_hold = 1; e_valid = 1; end
          else e_cksum = 1;
          m_active = 0;
        end
      end
    end else begin
      m_gap++;
      if (m_gap == TIMEOUT - 1) begin e_to = 1; m_active = 0; end
    end
    e_busy = m_active || m_hold;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cyc_valid",   frm_valid,   e_valid);
      chk("cyc_busy",    busy,        e_busy);
      chk("cyc_cmd",     frm_cmd,     e_cmd);
      chk("cyc_len",     frm_len,     e_len);
      chk("cyc_payload", frm_payload, e_pay);
      chk("cyc_cksum",   err_cksum,   e_cksum);
      chk("cyc_lenerr",  err_len,     e_lenerr);
      chk("cyc_timeout", err_timeout, e_to);
      chk("cyc_ovr",     err_ovr,     e_ovr);
    end
  end

  // Independent pulse counters for the directed checks.
  int n_cksum = 0, n_lenerr = 0, n_to = 0, n_ovr = 0;
  always @(negedge clk) begin
    if (err_cksum)   n_cksum++;
    if (err_len)     n_lenerr++;
    if (err_timeout) n_to++;
    if (err_ovr)     n_ovr++;
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rcv  = 1'b1;
    data = b;
    @(negedge clk);
    rcv  = 1'b0;
  endtask

  task automatic release_frame();
    @(negedge clk);
    frm_ready = 1'b1;
    @(negedge clk);
    frm_ready = 1'b0;
  endtask

  task automatic send_good();
    send(8'hAA); send(8'h10); send(8'h02); send(8'h05); send(8'h06); send(8'h1D);
  endtask

  int base;

  initial begin
    rstn = 1'b0; rcv = 1'b0; data = 8'h00; frm_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid",   frm_valid,   1'b0);
    chk("rst_busy",    busy,        1'b0);
    chk("rst_cmd",     frm_cmd,     8'h00);
    chk("rst_payload", frm_payload, {PW{1'b0}});
    rstn = 1'b1;

    // Good frame
    send_good();
    chk("good_valid",   frm_valid,   1'b1);
    chk("good_cmd",     frm_cmd,     8'h10);
    chk("good_len",     frm_len,     4'd2);
    chk("good_payload", frm_payload, {48'h0, 16'h0605});
    repeat (20) @(negedge clk);
    chk("good_hold_valid", frm_valid, 1'b1);
    chk("good_hold_pay",   frm_payload, {48'h0, 16'h0605});
    release_frame();
    chk("good_rel_valid", frm_valid, 1'b0);
    chk("good_rel_busy",  busy,      1'b0);

    // Garbage then zero-length frame
    base = n_cksum + n_lenerr + n_to + n_ovr;
    send(8'h55); send(8'h00);
    chk("garbage_busy", busy, 1'b0);
    send(8'hAA); send(8'h20); send(8'h00); send(8'h20);
    chk("zero_valid",   frm_valid,   1'b1);
    chk("zero_cmd",     frm_cmd,     8'h20);
    chk("zero_len",     frm_len,     4'd0);
    chk("zero_payload", frm_payload, {PW{1'b0}});
    chk("zero_noerr",   n_cksum + n_lenerr + n_to + n_ovr, base);
    release_frame();

    // Bad checksum, then bad length
    base = n_cksum;
    send(8'hAA); send(8'h10); send(8'h02); send(8'h05); send(8'h06); send(8'h1E);
    chk("cksum_pulse", err_cksum, 1'b1);
    chk("cksum_valid", frm_valid, 1'b0);
    @(negedge clk);
    chk("cksum_count", n_cksum - base, 1);
    base = n_lenerr;
    send(8'hAA); send(8'h01); send(8'h09);
    chk("len_pulse", err_len, 1'b1);
    chk("len_busy",  busy,    1'b0);
    @(negedge clk);
    chk("len_count", n_lenerr - base, 1);

    // Timeout: pulse 15 edges after the edge sampling 8'h10
    send(8'hAA); send(8'h10);
    repeat (14) @(negedge clk);
    chk("to_early", err_timeout, 1'b0);
    @(negedge clk);
    chk("to_pulse", err_timeout, 1'b1);
    @(negedge clk);
    chk("to_after", err_timeout, 1'b0);
    chk("to_busy",  busy,        1'b0);

    // Byte arriving on the expiry edge rescues the frame
    base = n_to;
    send(8'hAA); send(8'h10);
    repeat (13) @(negedge clk);
    send(8'h02); send(8'h05); send(8'h06); send(8'h1D);
    chk("rescue_valid", frm_valid, 1'b1);
    chk("rescue_noto",  n_to - base, 0);
    release_frame();

    // Overrun while holding
    send_good();
    base = n_ovr;
    send(8'hAA); send(8'h30); send(8'h00); send(8'h30);
    @(negedge clk);
    chk("ovr_count",   n_ovr - base, 4);
    chk("ovr_valid",   frm_valid,    1'b1);
    chk("ovr_cmd",     frm_cmd,      8'h10);
    chk("ovr_len",     frm_len,      4'd2);
    chk("ovr_payload", frm_payload,  {48'h0, 16'h0605});
    release_frame();

    // Reset mid-frame
    base = n_cksum + n_lenerr + n_to + n_ovr;
    send(8'hAA); send(8'h10); send(8'h02); send(8'h05);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("mid_valid",   frm_valid,   1'b0);
    chk("mid_busy",    busy,        1'b0);
    chk("mid_cmd",     frm_cmd,     8'h00);
    chk("mid_len",     frm_len,     4'd0);
    chk("mid_payload", frm_payload, {PW{1'b0}});
    send(8'hAA); send(8'h40); send(8'h01); send(8'h7F); send(8'hC0);
    chk("post_valid",   frm_valid,   1'b1);
    chk("post_cmd",     frm_cmd,     8'h40);
    chk("post_len",     frm_len,     4'd1);
    chk("post_payload", frm_payload, {56'h0, 8'h7F});
    chk("post_noerr",   n_cksum + n_lenerr + n_to + n_ovr, base);
    release_frame();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
